// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, mstatus/mip/mie bit positions, misa value and the masked-write helper.
package csr_pkg;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;
    localparam int MIP_MSIP = 3;
    localparam int MIP_MTIP = 7;
    localparam int MIP_MEIP = 11;
    localparam logic [31:0] MIE_MASK = 32'h0000_0888;
    localparam logic [31:0] MISA_VAL = 32'h4000_0100;

    function automatic logic [31:0] mwr(input logic [31:0] old_v, input logic [31:0] wdata,
                                        input logic [31:0] wmask);
        return (old_v & ~wmask) | (wdata & wmask);
    endfunction
endpackage

// File: rtl/csr_regfile_if.sv
// csr_regfile_if: core-side bus into the CSR file (read port, write port, trap/mret/interrupt controls).
interface csr_regfile_if;
    logic [11:0] rd_addr_i;
    logic [31:0] rd_data_o;
    logic        rd_illegal_o;
    logic [11:0] wr_addr_i;
    logic [31:0] wr_mask_i;
    logic [31:0] wr_data_i;
    logic        retire_i;
    logic        trap_i;
    logic [31:0] trap_cause_i;
    logic [31:0] trap_pc_i;
    logic [31:0] trap_tval_i;
    logic        mret_i;
    logic        irq_ext_i;
    logic        irq_timer_i;
    logic        irq_sw_i;
    logic [31:0] trap_vec_o;
    logic [31:0] mepc_o;
    logic        irq_req_o;

    modport master (
        output rd_addr_i, wr_addr_i, wr_mask_i, wr_data_i, retire_i, trap_i, trap_cause_i,
               trap_pc_i, trap_tval_i, mret_i, irq_ext_i, irq_timer_i, irq_sw_i,
        input  rd_data_o, rd_illegal_o, trap_vec_o, mepc_o, irq_req_o
    );
    modport slave (
        input  rd_addr_i, wr_addr_i, wr_mask_i, wr_data_i, retire_i, trap_i, trap_cause_i,
               trap_pc_i, trap_tval_i, mret_i, irq_ext_i, irq_timer_i, irq_sw_i,
        output rd_data_o, rd_illegal_o, trap_vec_o, mepc_o, irq_req_o
    );
endinterface

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit counter; a masked write to either half wins over the increment and freezes the other half.
module csr_counter64
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_wmask,
    output logic [63:0] o_value
);
    logic [63:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) r_cnt <= '0;
        else if (i_wr_lo) r_cnt[31:0] <= mwr(r_cnt[31:0], i_wdata, i_wmask);
        else if (i_wr_hi) r_cnt[63:32] <= mwr(r_cnt[63:32], i_wdata, i_wmask);
        else if (i_inc) r_cnt <= r_cnt + 64'd1;
    end

    assign o_value = r_cnt;
endmodule

// File: rtl/csr_regfile.sv
// csr_regfile: RV32 machine-mode CSR file with trap/mret sequencing and a registered interrupt request.
// Define CSR_COUNTERS_EN to implement mcycle/minstret; otherwise those addresses read 0.
module csr_regfile
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input logic clk,
    input logic rst,
    csr_regfile_if.slave bus
);
    logic        r_mie_b, r_mpie, r_irq;
    logic [31:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
    logic [31:0] w_mstatus, w_mip, w_base, w_rd_data;
    logic        w_wr, w_rd_ill;

    assign w_wr      = |bus.wr_mask_i && !bus.trap_i && !bus.mret_i;
    assign w_mstatus = MSTATUS_FIXED | ({31'd0, r_mie_b} << MSTATUS_MIE) | ({31'd0, r_mpie} << MSTATUS_MPIE);
    assign w_mip     = ({31'd0, bus.irq_ext_i} << MIP_MEIP) | ({31'd0, bus.irq_timer_i} << MIP_MTIP)
                     | ({31'd0, bus.irq_sw_i} << MIP_MSIP);
    assign w_base    = r_mtvec & ~32'h3;

    // Vectored mode only applies to interrupts; the 4*cause offset wraps at 32 bits.
    assign bus.trap_vec_o = (r_mtvec[0] && bus.trap_cause_i[31]) ? w_base + {bus.trap_cause_i[29:0], 2'b00} : w_base;
    assign bus.mepc_o     = r_mepc;
    assign bus.irq_req_o  = r_irq;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mie_b    <= 1'b0;
            r_mpie     <= 1'b0;
            r_mie      <= '0;
            r_mtvec    <= MTVEC_RESET & ~32'h2;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
        end else if (bus.trap_i) begin
            r_mepc   <= bus.trap_pc_i & ~32'h3;
            r_mcause <= bus.trap_cause_i;
            r_mtval  <= bus.trap_tval_i;
            r_mpie   <= r_mie_b;
            r_mie_b  <= 1'b0;
        end else if (bus.mret_i) begin
            r_mie_b <= r_mpie;
            r_mpie  <= 1'b1;
        end else if (w_wr) begin
            case (bus.wr_addr_i)
                CSR_MSTATUS: begin
                    r_mie_b <= bus.wr_mask_i[MSTATUS_MIE] ? bus.wr_data_i[MSTATUS_MIE] : r_mie_b;
                    r_mpie  <= bus.wr_mask_i[MSTATUS_MPIE] ? bus.wr_data_i[MSTATUS_MPIE] : r_mpie;
                end
                CSR_MIE:      r_mie      <= mwr(r_mie, bus.wr_data_i, bus.wr_mask_i) & MIE_MASK;
                CSR_MTVEC:    r_mtvec    <= mwr(r_mtvec, bus.wr_data_i, bus.wr_mask_i) & ~32'h2;
                CSR_MSCRATCH: r_mscratch <= mwr(r_mscratch, bus.wr_data_i, bus.wr_mask_i);
                CSR_MEPC:     r_mepc     <= mwr(r_mepc, bus.wr_data_i, bus.wr_mask_i) & ~32'h3;
                CSR_MCAUSE:   r_mcause   <= mwr(r_mcause, bus.wr_data_i, bus.wr_mask_i);
                CSR_MTVAL:    r_mtval    <= mwr(r_mtval, bus.wr_data_i, bus.wr_mask_i);
                default: ;
            endcase
        end
        r_irq <= rst && r_mie_b && |(w_mip & r_mie);
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] w_mcycle, w_minstret;

    csr_counter64 u_mcycle (
        .clk(clk), .rst(rst), .i_inc(1'b1),
        .i_wr_lo(w_wr && bus.wr_addr_i == CSR_MCYCLE), .i_wr_hi(w_wr && bus.wr_addr_i == CSR_MCYCLEH),
        .i_wdata(bus.wr_data_i), .i_wmask(bus.wr_mask_i), .o_value(w_mcycle)
    );
    csr_counter64 u_minstret (
        .clk(clk), .rst(rst), .i_inc(bus.retire_i),
        .i_wr_lo(w_wr && bus.wr_addr_i == CSR_MINSTRET), .i_wr_hi(w_wr && bus.wr_addr_i == CSR_MINSTRETH),
        .i_wdata(bus.wr_data_i), .i_wmask(bus.wr_mask_i), .o_value(w_minstret)
    );
`endif

    always_comb begin
        w_rd_data = '0;
        w_rd_ill  = 1'b0;
        case (bus.rd_addr_i)
            CSR_MSTATUS:  w_rd_data = w_mstatus;
            CSR_MISA:     w_rd_data = MISA_VAL;
            CSR_MHARTID:  w_rd_data = HART_ID;
            CSR_MIE:      w_rd_data = r_mie;
            CSR_MIP:      w_rd_data = w_mip;
            CSR_MTVEC:    w_rd_data = r_mtvec;
            CSR_MSCRATCH: w_rd_data = r_mscratch;
            CSR_MEPC:     w_rd_data = r_mepc;
            CSR_MCAUSE:   w_rd_data = r_mcause;
            CSR_MTVAL:    w_rd_data = r_mtval;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    w_rd_data = w_mcycle[31:0];
            CSR_MCYCLEH:   w_rd_data = w_mcycle[63:32];
            CSR_MINSTRET:  w_rd_data = w_minstret[31:0];
            CSR_MINSTRETH: w_rd_data = w_minstret[63:32];
`else
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: w_rd_data = '0;
`endif
            default:      w_rd_ill  = 1'b1;
        endcase
    end

    assign bus.rd_data_o    = w_rd_data;
    assign bus.rd_illegal_o = w_rd_ill;
endmodule

// File: tb/tb_csr_regfile.sv
// tb_csr_regfile: directed vectors for csr_regfile; counter checks follow the CSR_COUNTERS_EN build.
module tb_csr_regfile;
    import csr_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_vec = 0;
    int n_err = 0;
    logic [31:0] d;
    logic il;

    csr_regfile_if bus();

    csr_regfile #(.HART_ID(32'd3), .MTVEC_RESET(32'h0000_0400)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd_addr_i = '0; bus.wr_addr_i = '0; bus.wr_mask_i = '0; bus.wr_data_i = '0;
        bus.retire_i = 1'b0; bus.trap_i = 1'b0; bus.trap_cause_i = '0; bus.trap_pc_i = '0;
        bus.trap_tval_i = '0; bus.mret_i = 1'b0;
        bus.irq_ext_i = 1'b0; bus.irq_timer_i = 1'b0; bus.irq_sw_i = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] data, output logic ill);
        bus.rd_addr_i = a;
        #1;
        data = bus.rd_data_o;
        ill  = bus.rd_illegal_o;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] m, input logic [31:0] v);
        bus.wr_addr_i = a; bus.wr_mask_i = m; bus.wr_data_i = v;
        step();
        bus.wr_mask_i = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        bus.trap_i = 1'b1; bus.trap_pc_i = 32'h1234; bus.mret_i = 1'b1;
        bus.wr_addr_i = CSR_MSCRATCH; bus.wr_mask_i = '1; bus.wr_data_i = 32'hA5A5_A5A5;
        step(); step();
        rst = 1'b1;
        idle();
        #1;
        n_vec++; if (bus.irq_req_o !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b exp 0", bus.irq_req_o); end
        rd(CSR_MTVEC, d, il);
        n_vec++; if (d !== 32'h0000_0400) begin n_err++; $display("FAIL reset_mtvec got %h exp 00000400", d); end
        rd(12'h7C0, d, il);
        n_vec++; if (d !== 32'h0 || il !== 1'b1) begin n_err++; $display("FAIL unimpl_7c0 got %h/%b exp 00000000/1", d, il); end
        step();
        rd(CSR_MSCRATCH, d, il);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_mscratch got %h exp 00000000", d); end
        rd(CSR_MEPC, d, il);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_mepc got %h exp 00000000", d); end
        rd(CSR_MSTATUS, d, il);
        n_vec++; if (d !== 32'h0000_1800) begin n_err++; $display("FAIL reset_mstatus got %h exp 00001800", d); end
        step();
        rd(CSR_MISA, d, il);
        n_vec++; if (d !== 32'h4000_0100 || il !== 1'b0) begin n_err++; $display("FAIL misa got %h/%b exp 40000100/0", d, il); end
        rd(CSR_MHARTID, d, il);
        n_vec++; if (d !== 32'd3 || il !== 1'b0) begin n_err++; $display("FAIL mhartid got %h/%b exp 00000003/0", d, il); end
    endtask

    task automatic test_masked_write();
        wr(CSR_MSCRATCH, 32'hFFFF_FFFF, 32'hFFFF_0000);
        rd(CSR_MSCRATCH, d, il);
        n_vec++; if (d !== 32'hFFFF_0000) begin n_err++; $display("FAIL mscratch_full got %h exp ffff0000", d); end
        wr(CSR_MSCRATCH, 32'h0000_FFFF, 32'h1234_ABCD);
        rd(CSR_MSCRATCH, d, il);
        n_vec++; if (d !== 32'hFFFF_ABCD) begin n_err++; $display("FAIL mscratch_masked got %h exp ffffabcd", d); end
        wr(CSR_MISA, 32'hFFFF_FFFF, 32'h0);
        rd(CSR_MISA, d, il);
        n_vec++; if (d !== 32'h4000_0100) begin n_err++; $display("FAIL misa_ro got %h exp 40000100", d); end
        wr(CSR_MTVEC, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(CSR_MTVEC, d, il);
        n_vec++; if (d !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL mtvec_bit1 got %h exp fffffffd", d); end
        wr(CSR_MEPC, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(CSR_MEPC, d, il);
        n_vec++; if (d !== 32'hFFFF_FFFC || bus.mepc_o !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL mepc_low got %h/%h exp fffffffc", d, bus.mepc_o); end
        wr(CSR_MIE, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(CSR_MIE, d, il);
        n_vec++; if (d !== 32'h0000_0888) begin n_err++; $display("FAIL mie_bits got %h exp 00000888", d); end
        wr(CSR_MIE, 32'hFFFF_FFFF, 32'h0);
        bus.irq_ext_i = 1'b1; bus.irq_sw_i = 1'b1;
        rd(CSR_MIP, d, il);
        n_vec++; if (d !== 32'h0000_0808) begin n_err++; $display("FAIL mip_live got %h exp 00000808", d); end
        bus.irq_ext_i = 1'b0; bus.irq_sw_i = 1'b0;
    endtask

    task automatic test_trap_mret();
        wr(CSR_MSTATUS, 32'h0000_0008, 32'h0000_0008);
        wr(CSR_MTVEC, 32'hFFFF_FFFF, 32'h8000_0001);
        rd(CSR_MSTATUS, d, il);
        n_vec++; if (d !== 32'h0000_1808) begin n_err++; $display("FAIL mstatus_mie got %h exp 00001808", d); end
        bus.trap_cause_i = 32'h0000_0007;
        #1;
        n_vec++; if (bus.trap_vec_o !== 32'h8000_0000) begin n_err++; $display("FAIL trap_vec_exc got %h exp 80000000", bus.trap_vec_o); end
        bus.trap_i = 1'b1; bus.trap_cause_i = 32'h8000_0007; bus.trap_pc_i = 32'h100; bus.trap_tval_i = 32'hDEAD;
        #1;
        n_vec++; if (bus.trap_vec_o !== 32'h8000_001C) begin n_err++; $display("FAIL trap_vec_irq got %h exp 8000001c", bus.trap_vec_o); end
        step();
        idle();
        rd(CSR_MEPC, d, il);
        n_vec++; if (d !== 32'h100 || bus.mepc_o !== 32'h100) begin n_err++; $display("FAIL trap_mepc got %h/%h exp 00000100", d, bus.mepc_o); end
        rd(CSR_MCAUSE, d, il);
        n_vec++; if (d !== 32'h8000_0007) begin n_err++; $display("FAIL trap_mcause got %h exp 80000007", d); end
        rd(CSR_MTVAL, d, il);
        n_vec++; if (d !== 32'h0000_DEAD) begin n_err++; $display("FAIL trap_mtval got %h exp 0000dead", d); end
        rd(CSR_MSTATUS, d, il);
        n_vec++; if (d !== 32'h0000_1880) begin n_err++; $display("FAIL trap_mstatus got %h exp 00001880", d); end
        bus.mret_i = 1'b1;
        step();
        bus.mret_i = 1'b0;
        rd(CSR_MSTATUS, d, il);
        n_vec++; if (d !== 32'h0000_1888) begin n_err++; $display("FAIL mret_mstatus got %h exp 00001888", d); end
    endtask

    task automatic test_priority();
        bus.trap_i = 1'b1; bus.trap_cause_i = 32'h2; bus.trap_pc_i = 32'h204; bus.mret_i = 1'b1;
        wr(CSR_MSCRATCH, 32'hFFFF_FFFF, 32'h55);
        idle();
        rd(CSR_MSCRATCH, d, il);
        n_vec++; if (d !== 32'hFFFF_ABCD) begin n_err++; $display("FAIL prio_trap_mscratch got %h exp ffffabcd", d); end
        rd(CSR_MEPC, d, il);
        n_vec++; if (d !== 32'h204) begin n_err++; $display("FAIL prio_trap_mepc got %h exp 00000204", d); end
        rd(CSR_MSTATUS, d, il);
        n_vec++; if (d !== 32'h0000_1880) begin n_err++; $display("FAIL prio_trap_mstatus got %h exp 00001880", d); end
        bus.mret_i = 1'b1;
        wr(CSR_MSCRATCH, 32'hFFFF_FFFF, 32'h66);
        idle();
        rd(CSR_MSCRATCH, d, il);
        n_vec++; if (d !== 32'hFFFF_ABCD) begin n_err++; $display("FAIL prio_mret_mscratch got %h exp ffffabcd", d); end
        rd(CSR_MSTATUS, d, il);
        n_vec++; if (d !== 32'h0000_1888) begin n_err++; $display("FAIL prio_mret_mstatus got %h exp 00001888", d); end
    endtask

    task automatic test_irq();
        wr(CSR_MIE, 32'h0000_0080, 32'h0000_0080);
        bus.irq_timer_i = 1'b1;
        #1;
        n_vec++; if (bus.irq_req_o !== 1'b0) begin n_err++; $display("FAIL irq_before got %b exp 0", bus.irq_req_o); end
        step();
        n_vec++; if (bus.irq_req_o !== 1'b1) begin n_err++; $display("FAIL irq_assert got %b exp 1", bus.irq_req_o); end
        bus.trap_i = 1'b1; bus.trap_cause_i = 32'h8000_0007; bus.trap_pc_i = 32'h300;
        step();
        bus.trap_i = 1'b0;
        step();
        n_vec++; if (bus.irq_req_o !== 1'b0) begin n_err++; $display("FAIL irq_after_trap got %b exp 0", bus.irq_req_o); end
        idle();
    endtask

    task automatic test_counters();
`ifdef CSR_COUNTERS_EN
        wr(CSR_MCYCLEH, 32'hFFFF_FFFF, 32'h0);
        wr(CSR_MCYCLE, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(CSR_MCYCLE, d, il);
        n_vec++; if (d !== 32'hFFFF_FFFF || il !== 1'b0) begin n_err++; $display("FAIL mcycle_wr got %h/%b exp ffffffff/0", d, il); end
        rd(CSR_MCYCLEH, d, il);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL mcycleh_hold got %h exp 00000000", d); end
        step();
        rd(CSR_MCYCLE, d, il);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL mcycle_carry_lo got %h exp 00000000", d); end
        rd(CSR_MCYCLEH, d, il);
        n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL mcycle_carry_hi got %h exp 00000001", d); end
        wr(CSR_MCYCLE, 32'hFFFF_FFFF, 32'h5);
        rd(CSR_MCYCLE, d, il);
        n_vec++; if (d !== 32'h5) begin n_err++; $display("FAIL mcycle_wr_inc got %h exp 00000005", d); end
        rd(CSR_MCYCLEH, d, il);
        n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL mcycleh_after_wr got %h exp 00000001", d); end
        bus.retire_i = 1'b1;
        step(); step(); step();
        bus.retire_i = 1'b0;
        rd(CSR_MINSTRET, d, il);
        n_vec++; if (d !== 32'h3) begin n_err++; $display("FAIL minstret_count got %h exp 00000003", d); end
        bus.retire_i = 1'b1;
        wr(CSR_MINSTRET, 32'hFFFF_FFFF, 32'h7);
        bus.retire_i = 1'b0;
        rd(CSR_MINSTRET, d, il);
        n_vec++; if (d !== 32'h7) begin n_err++; $display("FAIL minstret_wr_retire got %h exp 00000007", d); end
        wr(CSR_MINSTRET, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wr(CSR_MINSTRETH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        bus.retire_i = 1'b1;
        step();
        bus.retire_i = 1'b0;
        rd(CSR_MINSTRET, d, il);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL minstret_wrap_lo got %h exp 00000000", d); end
        rd(CSR_MINSTRETH, d, il);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL minstret_wrap_hi got %h exp 00000000", d); end
`else
        rd(CSR_MCYCLE, d, il);
        n_vec++; if (d !== 32'h0 || il !== 1'b0) begin n_err++; $display("FAIL mcycle_off got %h/%b exp 00000000/0", d, il); end
        wr(CSR_MCYCLE, 32'hFFFF_FFFF, 32'h5);
        bus.retire_i = 1'b1;
        step();
        bus.retire_i = 1'b0;
        rd(CSR_MCYCLE, d, il);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL mcycle_off_wr got %h exp 00000000", d); end
        rd(CSR_MINSTRETH, d, il);
        n_vec++; if (d !== 32'h0 || il !== 1'b0) begin n_err++; $display("FAIL minstreth_off got %h/%b exp 00000000/0", d, il); end
`endif
    endtask

    initial begin
        test_reset();
        test_masked_write();
        test_trap_mret();
        test_priority();
        test_irq();
        test_counters();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
